// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle datapath controller: opcodes, FSM states,
// ALU operation codes and ALU B-operand select codes.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10
    } state_t;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_ADDI  = 3'b100;
    localparam logic [2:0] ALUOP_ANDI  = 3'b101;
    localparam logic [2:0] ALUOP_ORI   = 3'b111;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    // Unlisted opcodes map to FETCH, which is how DECODE abandons them.
    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_RTYPE:                  return S_REXEC;
            OP_LW, OP_SW:              return S_MEMADR;
            OP_ADDI, OP_ANDI, OP_ORI:  return S_IEXEC;
            OP_BEQ, OP_BNE:            return S_BRANCH;
            default:                   return S_FETCH;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return decode_target(op) != S_FETCH;
    endfunction

endpackage

// File: rtl/multicycle_control_outputs.sv
// Combinational output decode for the multicycle controller; reset forces every
// control line low and the debug state to zero.
module mc_ctrl_outputs
    import multicycle_control_pkg::*;
#(
    parameter int unsigned ALUOP_W = 3
) (
    input  logic               rst,
    input  state_t             cur_state,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dest,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic               ext_zero,
    output logic               pc_source,
    output logic               illegal_op,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [3:0]         state
);

    logic [2:0] aluop;
    logic       imm_zext;
    logic [2:0] imm_aluop;

    always_comb begin
        imm_zext  = (opcode == OP_ANDI) || (opcode == OP_ORI);
        imm_aluop = (opcode == OP_ANDI) ? ALUOP_ANDI :
                    (opcode == OP_ORI)  ? ALUOP_ORI  : ALUOP_ADDI;
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dest      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        ext_zero      = 1'b0;
        pc_source     = 1'b0;
        illegal_op    = 1'b0;
        alu_src_b     = SRCB_REGB;
        aluop         = ALUOP_ADD;
        if (!rst) begin
            case (cur_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = SRCB_IMMSH;
                    illegal_op = !is_legal(opcode);
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                // The write strobe fires only in the completing cycle so wait
                // cycles never repeat the store.
                S_MEMWR: begin
                    i_or_d    = 1'b1;
                    mem_write = mem_ready;
                end
                S_REXEC: begin
                    alu_src_a = 1'b1;
                    aluop     = ALUOP_FUNCT;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dest  = 1'b1;
                end
                S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    aluop     = imm_aluop;
                    ext_zero  = imm_zext;
                end
                S_IWB: begin
                    reg_write = 1'b1;
                    aluop     = imm_aluop;
                    ext_zero  = imm_zext;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    aluop         = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 1'b1;
                    branch_ne     = (opcode == OP_BNE);
                end
                default: ;
            endcase
        end
    end

    assign alu_op = ALUOP_W'(aluop);
    assign state  = rst ? 4'd0 : 4'(cur_state);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: state register plus next-state logic, with
// the control-line decode in mc_ctrl_outputs.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dest,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic               ext_zero,
    output logic               pc_source,
    output logic               illegal_op,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [3:0]         state
);

    state_t state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE: state_q <= decode_target(opcode);
                S_MEMADR: state_q <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
                S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
                S_REXEC:  state_q <= S_RWB;
                S_IEXEC:  state_q <= S_IWB;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    mc_ctrl_outputs #(.ALUOP_W(ALUOP_W)) u_outputs (
        .rst           (rst),
        .cur_state     (state_q),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dest      (reg_dest),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .ext_zero      (ext_zero),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .state         (state)
    );

endmodule
